// File: rtl/core_exec.sv
// -----------------------------------------------------------------------------
// core_exec
// Issue and writeback stage of the TOY core. Takes one decoded instruction at a
// time, drives operands and a function code into the registered ALU, waits out
// the ALU latency, then writes the result into the 16x16 register file or
// resolves a branch. Only one instruction is ever in flight.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   instr_valid_i/instr_i instruction handshake from fetch (op,d,s,t / addr)
//   instr_ready_o         high when idle and not halted
//   alu_op_o/a_o/b_o      registered ALU function and operands
//   alu_c_i               ALU result, ALU_LAT cycles after operand capture
//   retire_o              one-cycle completion pulse
//   br_valid_o/br_taken_o/br_target_o  branch resolution during writeback
//   halt_o                sticky halt, cleared only by reset
//   err_o                 one-cycle pulse for load/store opcodes
//   dbg_addr_i/dbg_data_o combinational register file peek (R0 reads 0)
// -----------------------------------------------------------------------------
module core_exec #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    input  logic [15:0] instr_i,
    output logic        instr_ready_o,
    output logic [2:0]  alu_op_o,
    output logic [15:0] alu_a_o,
    output logic [15:0] alu_b_o,
    input  logic [15:0] alu_c_i,
    output logic        retire_o,
    output logic        br_valid_o,
    output logic        br_taken_o,
    output logic [7:0]  br_target_o,
    output logic        halt_o,
    output logic        err_o,
    input  logic [3:0]  dbg_addr_i,
    output logic [15:0] dbg_data_o
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_instr;
    logic [15:0] r_rf [16];
    logic [2:0]  r_aluOp;
    logic [15:0] r_aluA;
    logic [15:0] r_aluB;
    logic        r_retire;
    logic        r_brValid;
    logic        r_halt;
    logic        r_err;

    logic [3:0]  w_op;
    logic [3:0]  w_d;
    logic [3:0]  w_s;
    logic [3:0]  w_t;
    logic        w_accept;
    logic        w_isAluOp;
    logic        w_isBranch;
    logic [2:0]  w_aluFn;
    logic [3:0]  w_lOp;
    logic [3:0]  w_lD;
    logic        w_lIsBranch;
    logic        w_lWrites;
    logic        w_brCond;
    logic [7:0]  w_brTarget;

    assign w_op       = instr_i[15:12];
    assign w_d        = instr_i[11:8];
    assign w_s        = instr_i[7:4];
    assign w_t        = instr_i[3:0];
    assign w_accept   = instr_valid_i && instr_ready_o;
    assign w_isAluOp  = (w_op >= 4'h1) && (w_op <= 4'h7);
    assign w_isBranch = (w_op == 4'hC) || (w_op == 4'hD) || (w_op == 4'hE);

    // Fields of the instruction currently in flight.
    assign w_lOp       = r_instr[15:12];
    assign w_lD        = r_instr[11:8];
    assign w_lIsBranch = (w_lOp == 4'hC) || (w_lOp == 4'hD) || (w_lOp == 4'hE);
    assign w_lWrites   = (w_lOp >= 4'h1) && (w_lOp <= 4'h7) && (w_lD != 4'h0);

    // TOY opcode to ALU function code; branches pass operand A through.
    always_comb begin
        w_aluFn = 3'd0;
        case (w_op)
            4'h1:                 w_aluFn = 3'd0;
            4'h2:                 w_aluFn = 3'd1;
            4'h3:                 w_aluFn = 3'd2;
            4'h4:                 w_aluFn = 3'd3;
            4'h5:                 w_aluFn = 3'd4;
            4'h6:                 w_aluFn = 3'd5;
            4'h7:                 w_aluFn = 3'd7;
            4'hC, 4'hD, 4'hE:     w_aluFn = 3'd6;
            default:              w_aluFn = 3'd0;
        endcase
    end

    // The ALU result only becomes valid during the WB cycle, so the branch
    // outcome is decoded combinationally from it and gated by the registered
    // br_valid pulse.
    always_comb begin
        w_brCond   = 1'b0;
        w_brTarget = r_instr[7:0];
        case (w_lOp)
            4'hC: w_brCond = (alu_c_i == 16'h0000);
            4'hD: w_brCond = !alu_c_i[15] && (alu_c_i != 16'h0000);
            4'hE: begin
                w_brCond   = 1'b1;
                w_brTarget = alu_c_i[7:0];
            end
            default: w_brCond = 1'b0;
        endcase
    end

    // Sequencer, operand issue and register file. Halt and load/store opcodes
    // skip EXEC and go straight to the one-cycle WB state with retire raised.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_instr   <= 16'h0000;
            r_aluOp   <= 3'd0;
            r_aluA    <= 16'h0000;
            r_aluB    <= 16'h0000;
            r_retire  <= 1'b0;
            r_brValid <= 1'b0;
            r_halt    <= 1'b0;
            r_err     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= 16'h0000;
            end
        end else begin
            r_retire  <= 1'b0;
            r_brValid <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_instr <= instr_i;
                        if (w_op == 4'h0) begin
                            r_halt   <= 1'b1;
                            r_retire <= 1'b1;
                            r_state  <= WB;
                        end else if (w_isAluOp || w_isBranch) begin
                            r_aluOp <= w_aluFn;
                            r_aluA  <= w_isBranch ? r_rf[w_d] : r_rf[w_s];
                            r_aluB  <= (w_op == 4'h7) ? {8'h00, instr_i[7:0]} : r_rf[w_t];
                            r_cnt   <= 3'd1;
                            r_state <= EXEC;
                        end else begin
                            r_err    <= 1'b1;
                            r_retire <= 1'b1;
                            r_state  <= WB;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == 3'(ALU_LAT)) begin
                        r_retire  <= 1'b1;
                        r_brValid <= w_lIsBranch;
                        r_state   <= WB;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                WB: begin
                    if (w_lWrites) begin
                        r_rf[w_lD] <= alu_c_i;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign instr_ready_o = (r_state == IDLE) && !r_halt;
    assign alu_op_o      = r_aluOp;
    assign alu_a_o       = r_aluA;
    assign alu_b_o       = r_aluB;
    assign retire_o      = r_retire;
    assign br_valid_o    = r_brValid;
    assign br_taken_o    = r_brValid && w_brCond;
    assign br_target_o   = r_brValid ? w_brTarget : 8'h00;
    assign halt_o        = r_halt;
    assign err_o         = r_err;
    assign dbg_data_o    = (dbg_addr_i == 4'h0) ? 16'h0000 : r_rf[dbg_addr_i];

endmodule

// File: tb/tb_core_exec.sv
// -----------------------------------------------------------------------------
// tb_core_exec
// Two core_exec instances (ALU_LAT = 1 and 3), each paired with a small
// pipelined ALU model, run the same directed program in parallel. Issuing an
// instruction pushes its expected completion into a per-unit queue; a monitor
// per unit pops and compares whenever retire_o is seen.
// -----------------------------------------------------------------------------
module tb_core_exec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rstN       [2] = '{1'b1, 1'b1};
    logic        instrValid [2] = '{1'b0, 1'b0};
    logic [15:0] instrW     [2] = '{16'h0000, 16'h0000};
    logic [3:0]  dbgAddr    [2] = '{4'h0, 4'h0};

    logic        ready    [2];
    logic        retire   [2];
    logic        brValid  [2];
    logic        brTaken  [2];
    logic        halt     [2];
    logic        err      [2];
    logic [7:0]  brTarget [2];
    logic [2:0]  aluOp    [2];
    logic [15:0] aluA     [2];
    logic [15:0] aluB     [2];
    logic [15:0] aluC     [2];
    logic [15:0] dbgData  [2];
    logic [15:0] aluPipe  [2][4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] word;
        int          acc;
        int          lat;
        bit          brV;
        bit          brT;
        logic [7:0]  tgt;
        bit          er;
        bit          wb;
        logic [3:0]  d;
        logic [15:0] val;
    } exp_t;

    exp_t q0 [$];
    exp_t q1 [$];

    // Registered 8-function ALU: first stage computes, later stages delay.
    function automatic logic [15:0] aluFn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            3'd4:    return a << b[3:0];
            3'd5:    return a >> b[3:0];
            3'd6:    return a;
            default: return b;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            aluPipe[u][0] <= aluFn(aluOp[u], aluA[u], aluB[u]);
            for (int k = 1; k < 4; k++) begin
                aluPipe[u][k] <= aluPipe[u][k-1];
            end
        end
    end

    assign aluC[0] = aluPipe[0][0];
    assign aluC[1] = aluPipe[1][2];

    core_exec #(.ALU_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rstN[0]),
        .instr_valid_i(instrValid[0]), .instr_i(instrW[0]), .instr_ready_o(ready[0]),
        .alu_op_o(aluOp[0]), .alu_a_o(aluA[0]), .alu_b_o(aluB[0]), .alu_c_i(aluC[0]),
        .retire_o(retire[0]), .br_valid_o(brValid[0]), .br_taken_o(brTaken[0]),
        .br_target_o(brTarget[0]), .halt_o(halt[0]), .err_o(err[0]),
        .dbg_addr_i(dbgAddr[0]), .dbg_data_o(dbgData[0])
    );

    core_exec #(.ALU_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rstN[1]),
        .instr_valid_i(instrValid[1]), .instr_i(instrW[1]), .instr_ready_o(ready[1]),
        .alu_op_o(aluOp[1]), .alu_a_o(aluA[1]), .alu_b_o(aluB[1]), .alu_c_i(aluC[1]),
        .retire_o(retire[1]), .br_valid_o(brValid[1]), .br_taken_o(brTaken[1]),
        .br_target_o(brTarget[1]), .halt_o(halt[1]), .err_o(err[1]),
        .dbg_addr_i(dbgAddr[1]), .dbg_data_o(dbgData[1])
    );

    function automatic int latOf(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic int qSize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic pushExp(input int u, input exp_t e);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic popExp(input int u, output exp_t e);
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic checkOutput(input string name, input int u, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL lat%0d %s: got %h expected %h", latOf(u), name, act, expv);
        end
    endtask

    // Presents a word and holds it until the DUT accepts it; acc is the cycle
    // in which valid and ready were both high.
    task automatic issueWord(input int u, input logic [15:0] w, output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        @(negedge clk);
        instrValid[u] = 1'b1;
        instrW[u]     = w;
        for (int i = 0; i < 60; i++) begin
            if (ready[u] === 1'b1) begin
                acc = cyc;
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput($sformatf("accept timeout %h", w), u, 0, 1);
    endtask

    task automatic applyStimulus(input int u, input logic [15:0] w, input bit quick,
                                 input bit brV, input bit brT, input logic [7:0] tgt,
                                 input bit er, input bit wb, input logic [3:0] d,
                                 input logic [15:0] val, output int acc);
        exp_t e;
        bit   ok;
        issueWord(u, w, acc, ok);
        if (ok) begin
            e.word = w;   e.acc = acc; e.lat = quick ? 1 : latOf(u) + 1;
            e.brV  = brV; e.brT = brT; e.tgt = tgt;
            e.er   = er;  e.wb  = wb;  e.d   = d;   e.val = val;
            pushExp(u, e);
        end
    endtask

    task automatic aluWb(input int u, input logic [15:0] w, input logic [3:0] d, input logic [15:0] val, output int acc);
        applyStimulus(u, w, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, d, val, acc);
    endtask

    task automatic branch(input int u, input logic [15:0] w, input bit taken, input logic [7:0] tgt);
        int acc;
        applyStimulus(u, w, 1'b0, 1'b1, taken, tgt, 1'b0, 1'b0, 4'h0, 16'h0000, acc);
    endtask

    task automatic quickOp(input int u, input logic [15:0] w, input bit er);
        int acc;
        applyStimulus(u, w, 1'b1, 1'b0, 1'b0, 8'h00, er, 1'b0, 4'h0, 16'h0000, acc);
    endtask

    task automatic idle(input int u);
        @(negedge clk);
        instrValid[u] = 1'b0;
    endtask

    task automatic monitorUnit(input int u);
        exp_t e;
        forever begin
            @(negedge clk);
            if (retire[u] === 1'b1) begin
                if (qSize(u) == 0) begin
                    checkOutput("unexpected retire", u, 1, 0);
                end else begin
                    popExp(u, e);
                    checkOutput($sformatf("retire latency %h", e.word), u, cyc - e.acc, e.lat);
                    checkOutput($sformatf("err_o %h", e.word), u, {31'd0, err[u]}, {31'd0, e.er});
                    checkOutput($sformatf("br_valid %h", e.word), u, {31'd0, brValid[u]}, {31'd0, e.brV});
                    if (e.brV) begin
                        checkOutput($sformatf("br_taken %h", e.word), u, {31'd0, brTaken[u]}, {31'd0, e.brT});
                        checkOutput($sformatf("br_target %h", e.word), u, {24'd0, brTarget[u]}, {24'd0, e.tgt});
                    end
                    if (e.wb) begin
                        dbgAddr[u] = e.d;
                        @(negedge clk);
                        checkOutput($sformatf("writeback R%0d %h", e.d, e.word), u, {16'd0, dbgData[u]}, {16'd0, e.val});
                    end
                end
            end
        end
    endtask

    task automatic runSuite(input int u);
        int a1, a2, a3, acc;
        bit ok, holdOk;
        @(negedge clk);
        rstN[u] = 1'b0;
        repeat (3) @(negedge clk);
        rstN[u] = 1'b1;
        @(negedge clk);
        checkOutput("reset ready", u, {31'd0, ready[u]}, 1);
        checkOutput("reset flags", u, {27'd0, retire[u], brValid[u], brTaken[u], halt[u], err[u]}, 0);
        checkOutput("reset br_target", u, {24'd0, brTarget[u]}, 0);
        checkOutput("reset alu outs", u, {13'd0, aluOp[u], aluA[u] | aluB[u]}, 0);

        aluWb(u, 16'h7107, 4'h1, 16'h0007, acc);
        aluWb(u, 16'h7205, 4'h2, 16'h0005, acc);
        aluWb(u, 16'h1312, 4'h3, 16'h000C, acc);
        aluWb(u, 16'h2423, 4'h4, 16'hFFF9, acc);
        aluWb(u, 16'h5512, 4'h5, 16'h00E0, acc);
        aluWb(u, 16'h7033, 4'h0, 16'h0000, acc);
        idle(u);
        repeat (2) @(negedge clk);

        // Valid stays high across these three words.
        aluWb(u, 16'h4612, 4'h6, 16'h0002, a1);
        aluWb(u, 16'h3712, 4'h7, 16'h0005, a2);
        aluWb(u, 16'h6851, 4'h8, 16'h0001, a3);
        checkOutput("issue interval 1", u, a2 - a1, latOf(u) + 2);
        checkOutput("issue interval 2", u, a3 - a2, latOf(u) + 2);
        aluWb(u, 16'h7FFF, 4'hF, 16'h00FF, acc);
        idle(u);

        branch(u, 16'hC040, 1'b1, 8'h40);
        branch(u, 16'hD410, 1'b0, 8'h10);
        branch(u, 16'hE300, 1'b1, 8'h0C);
        quickOp(u, 16'h8123, 1'b1);
        branch(u, 16'hE100, 1'b1, 8'h07);

        quickOp(u, 16'h0000, 1'b0);
        @(negedge clk);
        instrW[u] = 16'h7105;
        holdOk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready[u] !== 1'b0 || halt[u] !== 1'b1) holdOk = 1'b0;
        end
        checkOutput("halt held 20 cycles", u, {31'd0, holdOk}, 1);

        instrValid[u] = 1'b0;
        rstN[u] = 1'b0;
        @(negedge clk);
        rstN[u] = 1'b1;
        @(negedge clk);
        checkOutput("halt cleared by reset", u, {30'd0, halt[u], ready[u]}, 1);

        // Abort 0x7AFF in EXEC; nothing may retire for it.
        issueWord(u, 16'h7AFF, acc, ok);
        @(negedge clk);
        instrValid[u] = 1'b0;
        rstN[u] = 1'b0;
        @(negedge clk);
        rstN[u] = 1'b1;
        aluWb(u, 16'h1BAA, 4'hB, 16'h0000, acc);
        aluWb(u, 16'h7AFF, 4'hA, 16'h00FF, acc);
        idle(u);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        fork
            monitorUnit(0);
            monitorUnit(1);
        join
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fork
            runSuite(0);
            runSuite(1);
        join
        repeat (5) @(negedge clk);
        checkOutput("queue drained", 0, qSize(0), 0);
        checkOutput("queue drained", 1, qSize(1), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
